// File: rtl/branch_control_unit_if.sv
// Control bus between the branch control unit and the datapath: the
// instruction/condition inputs plus every register-enable, bus-drive and select line.
interface branch_control_unit_if;
   logic [31:0] IRregister;
   logic        CON;
   logic        PCin, MDRin, Zin, Yin, MARin, IRin, CONin, Rin;
   logic        PCout, MDRout, ZLOout, Cout, Rout;
   logic        Gra, Grb;
   logic        Read, IncPC;
   logic        Run;

   modport master (
      input  IRregister, CON,
      output PCin, MDRin, Zin, Yin, MARin, IRin, CONin, Rin,
      output PCout, MDRout, ZLOout, Cout, Rout,
      output Gra, Grb, Read, IncPC, Run
   );

   modport slave (
      output IRregister, CON,
      input  PCin, MDRin, Zin, Yin, MARin, IRin, CONin, Rin,
      input  PCout, MDRout, ZLOout, Cout, Rout,
      input  Gra, Grb, Read, IncPC, Run
   );
endinterface

// File: rtl/branch_control_unit.sv
// Moore control sequencer for fetch, br, jr, jal, nop and halt instructions.
// Outputs decode from the present state only; BR6 passes CON through to PCin.
module branch_control_unit (
   input  logic                   Clock,
   input  logic                   Reset_n,
   branch_control_unit_if.master  bus
);

   typedef enum logic [3:0] {
      RST, F0, F1, F2, DEC,
      BR3, BR4, BR5, BR6,
      JR3, JAL3, JAL4, HALT
   } state_t;

   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state, state_nxt;
   logic [4:0] opcode;
   logic       unused_ir;

   assign opcode    = bus.IRregister[31:27];
   assign unused_ir = ^bus.IRregister[26:0];

   always_ff @(posedge Clock) begin
      if (!Reset_n) state <= RST;
      else          state <= state_nxt;
   end

   // IR is loaded on the F2->DEC edge, so the opcode is only valid during DEC.
   always_comb begin
      state_nxt = state;
      unique case (state)
         RST:  state_nxt = F0;
         F0:   state_nxt = F1;
         F1:   state_nxt = F2;
         F2:   state_nxt = DEC;
         DEC: begin
            unique case (opcode)
               OP_BR:   state_nxt = BR3;
               OP_JR:   state_nxt = JR3;
               OP_JAL:  state_nxt = JAL3;
               OP_HALT: state_nxt = HALT;
               default: state_nxt = F0;
            endcase
         end
         BR3:  state_nxt = BR4;
         BR4:  state_nxt = BR5;
         BR5:  state_nxt = BR6;
         BR6:  state_nxt = F0;
         JR3:  state_nxt = F0;
         JAL3: state_nxt = JAL4;
         JAL4: state_nxt = F0;
         HALT: state_nxt = HALT;
         default: state_nxt = RST;
      endcase
   end

   always_comb begin
      bus.PCin   = 1'b0;
      bus.MDRin  = 1'b0;
      bus.Zin    = 1'b0;
      bus.Yin    = 1'b0;
      bus.MARin  = 1'b0;
      bus.IRin   = 1'b0;
      bus.CONin  = 1'b0;
      bus.Rin    = 1'b0;
      bus.PCout  = 1'b0;
      bus.MDRout = 1'b0;
      bus.ZLOout = 1'b0;
      bus.Cout   = 1'b0;
      bus.Rout   = 1'b0;
      bus.Gra    = 1'b0;
      bus.Grb    = 1'b0;
      bus.Read   = 1'b0;
      bus.IncPC  = 1'b0;
      bus.Run    = (state != RST) && (state != HALT);
      unique case (state)
         F0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         F1: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            bus.PCin  = 1'b1;
         end
         F2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         BR3: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.CONin = 1'b1;
         end
         BR4: begin
            bus.PCout = 1'b1;
            bus.Yin   = 1'b1;
         end
         BR5: begin
            bus.Cout = 1'b1;
            bus.Zin  = 1'b1;
         end
         BR6: begin
            bus.ZLOout = 1'b1;
            bus.PCin   = bus.CON;
         end
         JR3, JAL4: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.PCin = 1'b1;
         end
         JAL3: begin
            bus.PCout = 1'b1;
            bus.Grb   = 1'b1;
            bus.Rin   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_branch_control_unit.sv
// Bench for branch_control_unit: directed instructions, then random ones,
// compared cycle by cycle against a per-instruction micro-step sequence model.
module tb_branch_control_unit;

   logic Clock = 1'b0;
   logic Reset_n;

   branch_control_unit_if bus ();

   branch_control_unit dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clock = ~Clock;

   // Observed/expected vector layout, MSB first.
   localparam logic [17:0] RUN    = 18'h1 << 17;
   localparam logic [17:0] PCIN   = 18'h1 << 16;
   localparam logic [17:0] MDRIN  = 18'h1 << 15;
   localparam logic [17:0] ZIN    = 18'h1 << 14;
   localparam logic [17:0] YIN    = 18'h1 << 13;
   localparam logic [17:0] MARIN  = 18'h1 << 12;
   localparam logic [17:0] IRIN   = 18'h1 << 11;
   localparam logic [17:0] CONIN  = 18'h1 << 10;
   localparam logic [17:0] RIN    = 18'h1 << 9;
   localparam logic [17:0] PCOUT  = 18'h1 << 8;
   localparam logic [17:0] MDROUT = 18'h1 << 7;
   localparam logic [17:0] ZLOOUT = 18'h1 << 6;
   localparam logic [17:0] COUT   = 18'h1 << 5;
   localparam logic [17:0] ROUT   = 18'h1 << 4;
   localparam logic [17:0] GRA    = 18'h1 << 3;
   localparam logic [17:0] GRB    = 18'h1 << 2;
   localparam logic [17:0] READ   = 18'h1 << 1;
   localparam logic [17:0] INCPC  = 18'h1;

   localparam int NDIR = 7;
   logic [31:0] dir_ir   [NDIR] = '{32'h93100019, 32'h93100019, 32'h9B800000,
                                    32'hD0000000, 32'hA0000000, 32'h93100019,
                                    32'hD8000000};
   logic        dir_con  [NDIR] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic        dir_kill [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   int          total = 0;
   int          bad   = 0;
   int          dir_idx = 0;
   int          step;
   int          halt_cnt;
   logic        halted, pend_halt, kill;
   logic [17:0] q[$];

   task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%b want=%b", tag, $time, got, want);
      end
   endtask

   function automatic logic [17:0] obs();
      return {bus.Run, bus.PCin, bus.MDRin, bus.Zin, bus.Yin, bus.MARin, bus.IRin,
              bus.CONin, bus.Rin, bus.PCout, bus.MDRout, bus.ZLOout, bus.Cout,
              bus.Rout, bus.Gra, bus.Grb, bus.Read, bus.IncPC};
   endfunction

   // Picks the next instruction, drives it, and queues its expected micro-steps.
   task automatic start_instr();
      logic [31:0] ir;
      logic        con;
      logic [4:0]  op;
      int unsigned r;
      kill = 1'b0;
      if (dir_idx < NDIR) begin
         ir   = dir_ir[dir_idx];
         con  = dir_con[dir_idx];
         kill = dir_kill[dir_idx];
         dir_idx++;
      end else begin
         r = $urandom_range(0, 15);
         if (r < 4)       op = 5'b10010;
         else if (r < 7)  op = 5'b10011;
         else if (r < 10) op = 5'b10100;
         else if (r < 12) op = 5'b11010;
         else if (r < 13) op = 5'b11011;
         else             op = 5'($urandom);
         ir  = {op, 27'($urandom)};
         con = 1'($urandom);
      end
      bus.IRregister = ir;
      bus.CON        = con;
      op   = ir[31:27];
      step = 0;
      q = {RUN | PCOUT | MARIN | INCPC | ZIN,
           RUN | READ | MDRIN | PCIN,
           RUN | MDROUT | IRIN,
           RUN};
      case (op)
         5'b10010: q = {q, RUN | GRA | ROUT | CONIN, RUN | PCOUT | YIN, RUN | COUT | ZIN,
                        RUN | ZLOOUT | (con ? PCIN : 18'h0)};
         5'b10011: q = {q, RUN | GRA | ROUT | PCIN};
         5'b10100: q = {q, RUN | PCOUT | GRB | RIN, RUN | GRA | ROUT | PCIN};
         5'b11011: pend_halt = 1'b1;
         default: ;
      endcase
   endtask

   initial begin
      logic [17:0] want;
      logic        nr;
      int          cur;
      Reset_n        = 1'b0;
      bus.IRregister = '0;
      bus.CON        = 1'b0;
      halted = 1'b0; pend_halt = 1'b0; kill = 1'b0; halt_cnt = 0; step = 0;
      repeat (2) @(posedge Clock);
      #1 check_eq("reset", obs(), '0);
      Reset_n = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge Clock);
         #1;
         cur = -1;
         if (!Reset_n) begin
            want = '0;
            q.delete();
            halted = 1'b0; pend_halt = 1'b0; kill = 1'b0; halt_cnt = 0;
         end else if (halted) begin
            want = '0;
            halt_cnt++;
         end else begin
            if (q.size() == 0) start_instr();
            want = q.pop_front();
            cur  = step;
            step++;
            if (q.size() == 0 && pend_halt) begin
               halted = 1'b1; pend_halt = 1'b0; halt_cnt = 0;
            end
         end
         check_eq(halted ? "halt" : "step", obs(), want);

         nr = 1'b1;
         if (kill && cur == 5)                                 nr = 1'b0;
         else if (halted && halt_cnt >= 20)                    nr = 1'b0;
         else if (!Reset_n && $urandom_range(0, 2) == 0)       nr = 1'b0;
         else if (cyc > 200 && $urandom_range(0, 49) == 0)     nr = 1'b0;
         Reset_n = nr;

         // Reset and input changes between edges must not disturb the outputs.
         #3 check_eq("hold", obs(), want);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
